namuru_msync: RTL and testbench

Parametrised multi-channel input synchroniser for the Namuru GPS correlator. Brings asynchronous external signals (front-end PPS, TIC/measurement strobes, front-end status lines) into the `sys_clk` domain through a configurable flip-flop chain. Each channel adds a stability (glitch) filter, rise and fall pulse generation, per-channel edge selection, and sticky event/overflow flags with write-1-to-clear, so that software and the correlator can consume edges without polling races.

---
 rtl/namuru_msync.sv | 130 +++++++++++++
 tb/tb_namuru_msync.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/namuru_msync.sv
// -----------------------------------------------------------------------------
// namuru_msync
//
// Multi-channel input synchroniser for the Namuru GPS correlator. Each channel
// takes an asynchronous external line (PPS, TIC/measurement strobes, front-end
// status) and brings it into the sys_clk domain through a flip-flop chain. The
// chain is followed by a stability filter, rise/fall pulse generation,
// per-channel edge selection, and sticky event/overflow flags that are cleared
// by writing 1.
//
// Parameters
//   CHANNELS  number of independent channels (>= 1)
//   STAGES    synchroniser flip-flops per channel (>= 2)
//   FILTER    cycles a new synchronised level must hold before o follows it
//             (>= 1, 1 = no filtering)
//   INIT      per-channel reset value of the sync chain and o
//
// Ports
//   sys_clk   single clock
//   sys_rst   asynchronous, active-high reset
//   i         asynchronous inputs, one per channel
//   edge_sel  channel n uses [2n+1:2n]: 00 none, 01 rise, 10 fall, 11 both
//   clr       write-1-to-clear strobe for flag/ovf, one cycle
//   o         filtered synchronised level
//   rise      one-cycle pulse on a 0->1 transition of o
//   fall      one-cycle pulse on a 1->0 transition of o
//   evt       one-cycle pulse when a selected edge occurred ("event" is a
//             reserved word in SystemVerilog, hence the shortened name)
//   flag      sticky event flag
//   ovf       sticky overflow: an event arrived while flag was still set
// -----------------------------------------------------------------------------
module namuru_msync #(
    parameter int                    CHANNELS = 4,
    parameter int                    STAGES   = 3,
    parameter int                    FILTER   = 4,
    parameter logic [CHANNELS-1:0]   INIT     = '0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [CHANNELS-1:0]     i,
    input  logic [2*CHANNELS-1:0]   edge_sel,
    input  logic [CHANNELS-1:0]     clr,
    output logic [CHANNELS-1:0]     o,
    output logic [CHANNELS-1:0]     rise,
    output logic [CHANNELS-1:0]     fall,
    output logic [CHANNELS-1:0]     evt,
    output logic [CHANNELS-1:0]     flag,
    output logic [CHANNELS-1:0]     ovf
);

    // One extra bit over clog2 keeps FILTER = 1 (clog2 = 0) at a legal width.
    localparam int             CW       = $clog2(FILTER) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [STAGES-1:0] sync_reg;
            logic [CW-1:0]     cnt_reg;
            logic [CW-1:0]     cnt_next;
            logic              o_reg;
            logic              o_next;
            logic              sync_bit;
            logic              rise_reg;
            logic              fall_reg;
            logic              evt_reg;
            logic              flag_reg;
            logic              ovf_reg;
            logic              rise_cond;
            logic              fall_cond;

            assign sync_bit = sync_reg[STAGES-1];

            // Stability filter: the synchronised level must differ from o on
            // FILTER consecutive edges before o follows. Any cycle where it
            // agrees with o again throws away the partial count.
            always_comb begin
                o_next   = o_reg;
                cnt_next = '0;
                if (sync_bit != o_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        o_next = sync_bit;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Edge conditions are taken from the o update itself so the
            // pulses land on the same edge that changes o.
            assign rise_cond = o_next & ~o_reg;
            assign fall_cond = ~o_next & o_reg;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync_reg <= {STAGES{INIT[gi]}};
                    cnt_reg  <= '0;
                    o_reg    <= INIT[gi];
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    evt_reg  <= 1'b0;
                    flag_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[STAGES-2:0], i[gi]};
                    cnt_reg  <= cnt_next;
                    o_reg    <= o_next;
                    rise_reg <= rise_cond;
                    fall_reg <= fall_cond;
                    evt_reg  <= (rise_cond & edge_sel[2*gi]) |
                                (fall_cond & edge_sel[2*gi+1]);
                    // A new event beats a simultaneous clear for flag, but an
                    // event arriving together with a clear is not an overflow
                    // because software has just consumed the previous one.
                    flag_reg <= (flag_reg & ~clr[gi]) | evt_reg;
                    ovf_reg  <= (ovf_reg & ~clr[gi]) |
                                (evt_reg & flag_reg & ~clr[gi]);
                end
            end

            assign o[gi]    = o_reg;
            assign rise[gi] = rise_reg;
            assign fall[gi] = fall_reg;
            assign evt[gi]  = evt_reg;
            assign flag[gi] = flag_reg;
            assign ovf[gi]  = ovf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_namuru_msync.sv
// -----------------------------------------------------------------------------
// tb_namuru_msync
//
// Self-checking bench for namuru_msync with default parameters, plus a second
// instance with INIT = 4'b0101 for the reset-release behaviour. Expected pulses
// are pushed to a queue when an input change is driven; a per-negedge monitor
// collects observed rise/fall/evt pulses, and each scenario task pops and
// compares the two queues itself.
// -----------------------------------------------------------------------------
module tb_namuru_msync;

    localparam int CH  = 4;
    localparam int LAT = 6;   // STAGES + FILTER - 1 for the defaults

    typedef struct packed {
        logic [31:0] edge_n;
        logic [7:0]  ch;
        logic        r;
        logic        f;
        logic        e;
    } pulse_t;

    logic            sys_clk;
    logic            sys_rst;
    logic [CH-1:0]   i;
    logic [2*CH-1:0] edge_sel;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   o, rise, fall, evt, flag, ovf;

    logic [CH-1:0]   init_i;
    logic [2*CH-1:0] init_sel;
    logic [CH-1:0]   init_clr;
    logic [CH-1:0]   init_o, init_rise, init_fall, init_evt, init_flag, init_ovf;

    int     edge_cnt = 0;
    int     n_pass   = 0;
    int     n_checks = 0;
    int     init_pulses = 0;
    int     flag_edge [CH];
    logic [CH-1:0] flag_seen = '0;
    pulse_t exp_q [$];
    pulse_t obs_q [$];
    pulse_t exp_p, obs_p;

    namuru_msync dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i        (i),
        .edge_sel (edge_sel),
        .clr      (clr),
        .o        (o),
        .rise     (rise),
        .fall     (fall),
        .evt      (evt),
        .flag     (flag),
        .ovf      (ovf)
    );

    namuru_msync #(.INIT(4'b0101)) dut_init (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i        (init_i),
        .edge_sel (init_sel),
        .clr      (init_clr),
        .o        (init_o),
        .rise     (init_rise),
        .fall     (init_fall),
        .evt      (init_evt),
        .flag     (init_flag),
        .ovf      (init_ovf)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    function automatic pulse_t mk(int e_n, int c, logic r, logic f, logic e);
        pulse_t p;
        p.edge_n = e_n;
        p.ch     = 8'(c);
        p.r      = r;
        p.f      = f;
        p.e      = e;
        return p;
    endfunction

    // Advance to the next falling edge and record what the DUTs show there.
    task automatic step();
        @(negedge sys_clk);
        for (int c = 0; c < CH; c++) begin
            if (rise[c] || fall[c] || evt[c])
                obs_q.push_back(mk(edge_cnt, c, rise[c], fall[c], evt[c]));
            if (flag[c] && !flag_seen[c]) flag_edge[c] = edge_cnt;
            flag_seen[c] = flag[c];
        end
        if ((init_rise | init_fall | init_evt) != '0) init_pulses++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({o, rise, fall, evt, flag, ovf} !== '0)
            $display("FAIL reset_outputs: got o=%b rise=%b fall=%b evt=%b flag=%b ovf=%b, expected all 0",
                     o, rise, fall, evt, flag, ovf);
        else n_pass++;
        n_checks++;
        if (init_o !== 4'b0101)
            $display("FAIL reset_init_o: got %b, expected 0101", init_o);
        else n_pass++;
        sys_rst = 1'b0;
        repeat (20) step();
        n_checks++;
        if (init_pulses !== 0 || init_o !== 4'b0101)
            $display("FAIL init_release: got %0d pulses o=%b, expected 0 pulses o=0101",
                     init_pulses, init_o);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 0)
            $display("FAIL reset_release_pulses: got %0d pulses, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_rise();
        int k;
        i[0] = 1'b1;
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 0, 1'b1, 1'b0, 1'b1));
        repeat (12) step();
        while (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL rise_pulse: got none, expected edge=%0d ch=%0d rfe=%b%b%b",
                         exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
            else begin
                obs_p = obs_q.pop_front();
                if (obs_p !== exp_p)
                    $display("FAIL rise_pulse: got edge=%0d ch=%0d rfe=%b%b%b, expected edge=%0d ch=%0d rfe=%b%b%b",
                             obs_p.edge_n, obs_p.ch, obs_p.r, obs_p.f, obs_p.e,
                             exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rise_extra: got %0d extra pulses, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        n_checks++;
        if (flag_edge[0] !== k + LAT + 1)
            $display("FAIL rise_flag_edge: got %0d, expected %0d", flag_edge[0], k + LAT + 1);
        else n_pass++;
        clr = 4'b0001;
        step();
        clr = '0;
        n_checks++;
        if (flag[0] !== 1'b0)
            $display("FAIL rise_flag_clr: got %b, expected 0", flag[0]);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int k;
        i[1] = 1'b1;
        repeat (3) step();
        i[1] = 1'b0;
        repeat (12) step();
        n_checks++;
        if (obs_q.size() !== 0 || o[1] !== 1'b0)
            $display("FAIL glitch_reject: got %0d pulses o1=%b, expected 0 pulses o1=0",
                     obs_q.size(), o[1]);
        else n_pass++;
        obs_q.delete();
        i[1] = 1'b1;
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 1, 1'b1, 1'b0, 1'b1));
        repeat (4) step();
        i[1] = 1'b0;
        exp_q.push_back(mk(k + 4 + LAT, 1, 1'b0, 1'b1, 1'b0));
        repeat (14) step();
        while (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL glitch_pass: got none, expected edge=%0d ch=%0d rfe=%b%b%b",
                         exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
            else begin
                obs_p = obs_q.pop_front();
                if (obs_p !== exp_p)
                    $display("FAIL glitch_pass: got edge=%0d ch=%0d rfe=%b%b%b, expected edge=%0d ch=%0d rfe=%b%b%b",
                             obs_p.edge_n, obs_p.ch, obs_p.r, obs_p.f, obs_p.e,
                             exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL glitch_extra: got %0d extra pulses, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        clr = 4'b0010;
        step();
        clr = '0;
    endtask

    task automatic test_fall_select();
        int k;
        i[2] = 1'b1;
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 2, 1'b1, 1'b0, 1'b0));
        repeat (10) step();
        i[2] = 1'b0;
        exp_q.push_back(mk(k + 10 + LAT, 2, 1'b0, 1'b1, 1'b1));
        repeat (10) step();
        while (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL fall_sel: got none, expected edge=%0d ch=%0d rfe=%b%b%b",
                         exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
            else begin
                obs_p = obs_q.pop_front();
                if (obs_p !== exp_p)
                    $display("FAIL fall_sel: got edge=%0d ch=%0d rfe=%b%b%b, expected edge=%0d ch=%0d rfe=%b%b%b",
                             obs_p.edge_n, obs_p.ch, obs_p.r, obs_p.f, obs_p.e,
                             exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL fall_sel_extra: got %0d extra pulses, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        n_checks++;
        if (flag[2] !== 1'b1 || ovf[2] !== 1'b0)
            $display("FAIL fall_sel_flag: got flag=%b ovf=%b, expected flag=1 ovf=0", flag[2], ovf[2]);
        else n_pass++;
        clr = 4'b0100;
        step();
        clr = '0;
    endtask

    task automatic test_overflow();
        int k;
        i[3] = 1'b1;
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 3, 1'b1, 1'b0, 1'b1));
        repeat (10) step();
        i[3] = 1'b0;
        exp_q.push_back(mk(k + 10 + LAT, 3, 1'b0, 1'b1, 1'b1));
        repeat (10) step();
        n_checks++;
        if (flag[3] !== 1'b1 || ovf[3] !== 1'b1)
            $display("FAIL ovf_set: got flag=%b ovf=%b, expected flag=1 ovf=1", flag[3], ovf[3]);
        else n_pass++;
        clr = 4'b1000;
        step();
        clr = '0;
        n_checks++;
        if (flag[3] !== 1'b0 || ovf[3] !== 1'b0)
            $display("FAIL ovf_clr: got flag=%b ovf=%b, expected flag=0 ovf=0", flag[3], ovf[3]);
        else n_pass++;
        // Re-arm the flag, then clear it in the very cycle the next event shows.
        i[3] = 1'b1;
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 3, 1'b1, 1'b0, 1'b1));
        repeat (10) step();
        i[3] = 1'b0;
        exp_q.push_back(mk(k + 10 + LAT, 3, 1'b0, 1'b1, 1'b1));
        repeat (7) step();
        clr = 4'b1000;
        step();
        clr = '0;
        n_checks++;
        if (flag[3] !== 1'b1 || ovf[3] !== 1'b0)
            $display("FAIL ovf_clr_coincident: got flag=%b ovf=%b, expected flag=1 ovf=0", flag[3], ovf[3]);
        else n_pass++;
        repeat (2) step();
        while (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL ovf_pulse: got none, expected edge=%0d ch=%0d rfe=%b%b%b",
                         exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
            else begin
                obs_p = obs_q.pop_front();
                if (obs_p !== exp_p)
                    $display("FAIL ovf_pulse: got edge=%0d ch=%0d rfe=%b%b%b, expected edge=%0d ch=%0d rfe=%b%b%b",
                             obs_p.edge_n, obs_p.ch, obs_p.r, obs_p.f, obs_p.e,
                             exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL ovf_extra: got %0d extra pulses, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int k;
        i[0] = 1'b0;
        i[1] = 1'b1;
        repeat (10) step();
        obs_q.delete();
        i[0] = 1'b1;
        repeat (4) step();          // ch0 filter is part-way through its count
        #2 sys_rst = 1'b1;
        #1;
        n_checks++;
        if ({o, rise, fall, evt, flag, ovf} !== '0)
            $display("FAIL reset_async: got o=%b rise=%b fall=%b evt=%b flag=%b ovf=%b, expected all 0",
                     o, rise, fall, evt, flag, ovf);
        else n_pass++;
        repeat (2) step();
        sys_rst = 1'b0;
        obs_q.delete();
        k = edge_cnt + 1;
        exp_q.push_back(mk(k + LAT, 0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(k + LAT, 1, 1'b1, 1'b0, 1'b1));
        repeat (10) step();
        while (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL reset_mid_pulse: got none, expected edge=%0d ch=%0d rfe=%b%b%b",
                         exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
            else begin
                obs_p = obs_q.pop_front();
                if (obs_p !== exp_p)
                    $display("FAIL reset_mid_pulse: got edge=%0d ch=%0d rfe=%b%b%b, expected edge=%0d ch=%0d rfe=%b%b%b",
                             obs_p.edge_n, obs_p.ch, obs_p.r, obs_p.f, obs_p.e,
                             exp_p.edge_n, exp_p.ch, exp_p.r, exp_p.f, exp_p.e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL reset_mid_extra: got %0d extra pulses, expected 0", obs_q.size());
        else n_pass++;
        n_checks++;
        if (o !== 4'b0011)
            $display("FAIL reset_mid_o: got %b, expected 0011", o);
        else n_pass++;
    endtask

    initial begin
        sys_rst  = 1'b1;
        i        = '0;
        clr      = '0;
        edge_sel = {2'b11, 2'b10, 2'b01, 2'b01};
        init_i   = 4'b0101;
        init_sel = '1;
        init_clr = '0;
        for (int c = 0; c < CH; c++) flag_edge[c] = -1;

        test_reset();
        test_rise();
        test_glitch();
        test_fall_select();
        test_overflow();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
